// File: rtl/dpram_arbiter.sv
// Two-requester arbiter for a shared dual-port RAM: independent round-robin
// write and read ports, plus a fill engine that takes over the write port.
module dpram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req_a,
  input  logic          wr_req_b,
  input  logic [AW-1:0] wr_addr_a,
  input  logic [AW-1:0] wr_addr_b,
  input  logic [DW-1:0] wr_data_a,
  input  logic [DW-1:0] wr_data_b,
  output logic          wr_gnt_a,
  output logic          wr_gnt_b,
  input  logic          rd_req_a,
  input  logic          rd_req_b,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_gnt_a,
  output logic          rd_gnt_b,
  output logic          rd_valid_a,
  output logic          rd_valid_b,
  output logic [DW-1:0] rd_data,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_data,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          mem_write,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_next;
  logic [AW-1:0] counter;
  logic [DW-1:0] fill_val;
  logic          wr_ptr;  // 0 favours A, 1 favours B
  logic          rd_ptr;

  assign rd_data = mem_rdata;

  always_comb begin
    state_next = state;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: if (fill_start) state_next = FILL;
      FILL: begin
        fill_busy = 1'b1;
        fill_done = (counter == '1);
        if (counter == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill owns the write port outright; requesters see no grant meanwhile.
  always_comb begin
    wr_gnt_a  = 1'b0;
    wr_gnt_b  = 1'b0;
    mem_write = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state == FILL) begin
        mem_write = 1'b1;
        mem_waddr = counter;
        mem_wdata = fill_val;
      end else begin
        wr_gnt_a = wr_req_a && (!wr_req_b || !wr_ptr);
        wr_gnt_b = wr_req_b && (!wr_req_a ||  wr_ptr);
        if (wr_gnt_a) begin
          mem_write = 1'b1;
          mem_waddr = wr_addr_a;
          mem_wdata = wr_data_a;
        end else if (wr_gnt_b) begin
          mem_write = 1'b1;
          mem_waddr = wr_addr_b;
          mem_wdata = wr_data_b;
        end
      end
    end
  end

  always_comb begin
    rd_gnt_a  = 1'b0;
    rd_gnt_b  = 1'b0;
    mem_read  = 1'b0;
    mem_raddr = '0;
    if (!reset) begin
      rd_gnt_a = rd_req_a && (!rd_req_b || !rd_ptr);
      rd_gnt_b = rd_req_b && (!rd_req_a ||  rd_ptr);
      if (rd_gnt_a) begin
        mem_read  = 1'b1;
        mem_raddr = rd_addr_a;
      end else if (rd_gnt_b) begin
        mem_read  = 1'b1;
        mem_raddr = rd_addr_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      fill_val   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && fill_start) begin
        counter  <= '0;
        fill_val <= fill_data;
      end else if (state == FILL) begin
        counter <= counter + 1'b1;
      end
      if (wr_gnt_a)      wr_ptr <= 1'b1;
      else if (wr_gnt_b) wr_ptr <= 1'b0;
      if (rd_gnt_a)      rd_ptr <= 1'b1;
      else if (rd_gnt_b) rd_ptr <= 1'b0;
      rd_valid_a <= rd_gnt_a;
      rd_valid_b <= rd_gnt_b;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a registered-read RAM model attached.
module tb_dpram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req_a, wr_req_b, rd_req_a, rd_req_b;
  logic [3:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic       wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic       rd_valid_a, rd_valid_b;
  logic [7:0] rd_data;
  logic       fill_start;
  logic [7:0] fill_data;
  logic       fill_busy, fill_done;
  logic       mem_write, mem_read;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] ram [16];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  // Read and write in one edge: nonblocking update returns pre-write data.
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_raddr];
  end

  dpram_arbiter #(.DW(8), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .wr_req_a(wr_req_a), .wr_req_b(wr_req_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .wr_gnt_a(wr_gnt_a), .wr_gnt_b(wr_gnt_b),
    .rd_req_a(rd_req_a), .rd_req_b(rd_req_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_gnt_a(rd_gnt_a), .rd_gnt_b(rd_gnt_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .rd_data(rd_data),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_req_a = 0; wr_req_b = 0; rd_req_a = 0; rd_req_b = 0;
    wr_addr_a = 0; wr_addr_b = 0; rd_addr_a = 0; rd_addr_b = 0;
    wr_data_a = 0; wr_data_b = 0; fill_start = 0; fill_data = 0;
    repeat (2) @(negedge clk);

    // Reset state and forced-off grants
    wr_req_a = 1; rd_req_b = 1; #1;
    chk("rst_wr_gnt_a", wr_gnt_a, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rd_gnt_b", rd_gnt_b, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_rd_valid_a", rd_valid_a, 0);
    chk("rst_rd_valid_b", rd_valid_b, 0);
    @(negedge clk); reset = 0; wr_req_a = 0; rd_req_b = 0; #1;
    chk("rst_no_valid_b", rd_valid_b, 0);

    // Both writers held 4 cycles: A,B,A,B
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_req_a = 1; wr_req_b = 1;
      wr_addr_a = 4'(i);     wr_data_a = 8'(8'hA0 + i);
      wr_addr_b = 4'(8 + i); wr_data_b = 8'(8'hB0 + i);
      #1;
      chk("rr_wr_gnt_a", wr_gnt_a, (i % 2 == 0));
      chk("rr_wr_gnt_b", wr_gnt_b, (i % 2 == 1));
      chk("rr_waddr", mem_waddr, (i % 2 == 0) ? i : 8 + i);
    end
    @(negedge clk); wr_req_a = 0; wr_req_b = 0; #1;
    chk("rr_ram0", ram[0], 8'hA0);
    chk("rr_ram9", ram[9], 8'hB1);
    chk("rr_ram2", ram[2], 8'hA2);
    chk("rr_ram11", ram[11], 8'hB3);
    chk("idle_mem_write", mem_write, 0);

    // Lone writer B, then read back via A
    @(negedge clk); wr_req_b = 1; wr_addr_b = 3; wr_data_b = 8'h5A; #1;
    chk("lone_wr_gnt_b", wr_gnt_b, 1);
    chk("lone_wr_gnt_a", wr_gnt_a, 0);
    chk("lone_wdata", mem_wdata, 8'h5A);
    @(negedge clk); wr_req_b = 0; rd_req_a = 1; rd_addr_a = 3; #1;
    chk("lone_rd_gnt_a", rd_gnt_a, 1);
    chk("lone_raddr", mem_raddr, 3);
    @(negedge clk); rd_req_a = 0; #1;
    chk("lone_rd_valid_a", rd_valid_a, 1);
    chk("lone_rd_valid_b", rd_valid_b, 0);
    chk("lone_rd_data", rd_data, 8'h5A);
    @(negedge clk); #1;
    chk("lone_valid_drop", rd_valid_a, 0);

    // Fill 0xC3 with writer A held; reads of addr 0 alternate during fill
    @(negedge clk);
    fill_start = 1; fill_data = 8'hC3;
    wr_req_a = 1; wr_addr_a = 5; wr_data_a = 8'h77; #1;
    chk("fs_wr_gnt_a", wr_gnt_a, 1);
    chk("fs_fill_busy", fill_busy, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      fill_start = (k == 3);
      fill_data  = (k == 3) ? 8'h99 : 8'h00;
      rd_req_a = (k < 4); rd_req_b = (k < 4);
      rd_addr_a = 0; rd_addr_b = 0;
      #1;
      chk("fill_busy", fill_busy, 1);
      chk("fill_wr_gnt_a", wr_gnt_a, 0);
      chk("fill_waddr", mem_waddr, k);
      chk("fill_wdata", mem_wdata, 8'hC3);
      chk("fill_done", fill_done, (k == 15));
      if (k < 4) begin
        chk("fill_rd_gnt_b", rd_gnt_b, (k % 2 == 0));
        chk("fill_rd_gnt_a", rd_gnt_a, (k % 2 == 1));
      end
      if (k >= 1 && k <= 4) begin
        chk("fill_rd_valid_b", rd_valid_b, (k % 2 == 1));
        chk("fill_rd_valid_a", rd_valid_a, (k % 2 == 0));
        chk("fill_rd_data", rd_data, (k == 1) ? 8'hA0 : 8'hC3);
      end
    end
    @(negedge clk); fill_start = 0; #1;
    chk("post_fill_busy", fill_busy, 0);
    chk("post_fill_done", fill_done, 0);
    chk("post_wr_gnt_a", wr_gnt_a, 1);
    for (int a = 0; a < 16; a++) chk("fill_ram", ram[a], 8'hC3);
    @(negedge clk); wr_req_a = 0;

    // Reset at fill cycle 5 aborts; restart accepted
    @(negedge clk); fill_start = 1; fill_data = 8'h5C; #1;
    chk("abort_start_busy", fill_busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); fill_start = 0; fill_data = 0;
      if (k == 5) reset = 1;
      #1;
      chk("abort_busy", fill_busy, 1);
      chk("abort_mem_write", mem_write, (k != 5));
    end
    @(negedge clk); reset = 0; #1;
    chk("abort_busy_clr", fill_busy, 0);
    for (int a = 0; a < 5; a++) chk("abort_ram", ram[a], 8'h5C);
    chk("abort_ram5", ram[5], 8'h77);
    chk("abort_ram6", ram[6], 8'hC3);
    @(negedge clk); fill_start = 1; fill_data = 8'h3E;
    @(negedge clk); fill_start = 0; #1;
    chk("restart_busy", fill_busy, 1);
    chk("restart_waddr", mem_waddr, 0);
    chk("restart_wdata", mem_wdata, 8'h3E);
    reset = 1;
    @(negedge clk); reset = 0; #1;
    chk("restart_abort", fill_busy, 0);

    // Pointers back at A; same-address read/write returns old data
    @(negedge clk);
    wr_req_a = 1; wr_addr_a = 7;  wr_data_a = 8'h22;
    wr_req_b = 1; wr_addr_b = 12; wr_data_b = 8'h44;
    rd_req_a = 1; rd_req_b = 1; rd_addr_a = 13; rd_addr_b = 13; #1;
    chk("ptr_wr_gnt_a", wr_gnt_a, 1);
    chk("ptr_wr_gnt_b", wr_gnt_b, 0);
    chk("ptr_rd_gnt_a", rd_gnt_a, 1);
    chk("ptr_rd_gnt_b", rd_gnt_b, 0);
    @(negedge clk);
    wr_req_a = 0; wr_req_b = 1; wr_addr_b = 7; wr_data_b = 8'h11;
    rd_req_a = 0; rd_req_b = 1; rd_addr_b = 7; #1;
    chk("raw_wr_gnt_b", wr_gnt_b, 1);
    chk("raw_rd_gnt_b", rd_gnt_b, 1);
    chk("raw_prev_valid_a", rd_valid_a, 1);
    chk("raw_prev_data", rd_data, 8'hC3);
    @(negedge clk); wr_req_b = 0; #1;
    chk("raw_valid_b", rd_valid_b, 1);
    chk("raw_old_data", rd_data, 8'h22);
    chk("raw_rd_gnt_b2", rd_gnt_b, 1);
    @(negedge clk); rd_req_b = 0; #1;
    chk("raw_valid_b2", rd_valid_b, 1);
    chk("raw_new_data", rd_data, 8'h11);
    @(negedge clk); #1;
    chk("end_valid_b", rd_valid_b, 0);
    chk("end_mem_read", mem_read, 0);
    chk("end_raddr", mem_raddr, 0);
    chk("end_mem_write", mem_write, 0);
    chk("end_waddr", mem_waddr, 0);
    chk("end_wdata", mem_wdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of the shared 16-entry dual-port RAM.
REQ-002 Parameter AW, default 4, address width; depth is 2**AW.
REQ-003 clk  in  1  rising-edge clock; reset is synchronous, active-high, and the block samples it on clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 wr_req_a / wr_req_b  in  1  write request from requester A / B; held until granted.
REQ-006 wr_addr_a / wr_addr_b  in  AW  write address, valid while the request is high.
REQ-007 wr_data_a / wr_data_b  in  DW  write data, valid while the request is high.
REQ-008 wr_gnt_a / wr_gnt_b  out  1  combinational write grant; the write commits at the next clk edge.
REQ-009 rd_req_a / rd_req_b  in  1  read request from requester A / B; held until granted.
REQ-010 rd_addr_a / rd_addr_b  in  AW  read address, valid while the request is high.
REQ-011 rd_gnt_a / rd_gnt_b  out  1  combinational read grant.
REQ-012 rd_valid_a / rd_valid_b  out  1  registered; high the cycle after the matching rd_gnt.
REQ-013 rd_data  out  DW  equals mem_rdata and is meaningful only while rd_valid_a or rd_valid_b is high.
REQ-014 fill_start  in  1  single-cycle pulse requesting a fill of all 2**AW locations.
REQ-015 fill_data  in  DW  fill value, captured in the cycle fill_start is accepted.
REQ-016 fill_busy  out  1  high while the fill engine owns the write port.
REQ-017 fill_done  out  1  single-cycle pulse marking the final fill write.
REQ-018 mem_write, mem_waddr (AW), mem_wdata (DW)  out  RAM write port, driven combinationally.
REQ-019 mem_read, mem_raddr (AW)  out  RAM read port, driven combinationally.
REQ-020 mem_rdata  in  DW  registered RAM read data; the RAM updates it one clk after mem_read.

Function
REQ-021 Write and read ports SHALL be arbitrated independently, with at most one grant per port per cycle.
REQ-022 Each port SHALL keep a 1-bit round-robin pointer; with both requesters active, the pointed-to requester wins.
REQ-023 After any write grant to X, the write pointer SHALL point to the other requester; the read pointer behaves the same way for read grants.
REQ-024 A lone requester SHALL be granted in the same cycle it requests, with zero added latency.
REQ-025 A write grant SHALL drive mem_write=1 with the winner's address and data; with no grant, mem_write=0, mem_waddr=0 and mem_wdata=0.
REQ-026 A read grant SHALL drive mem_read=1 with the winner's address; the matching rd_valid SHALL be high in the next cycle.
REQ-027 With no read grant, mem_read=0 and mem_raddr=0, and no rd_valid SHALL follow.
REQ-028 The fill FSM has two states, IDLE and FILL; IDLE moves to FILL at the edge where fill_start=1, capturing fill_data and clearing the counter to 0.
REQ-029 In FILL, fill_busy=1; each cycle the block SHALL write the captured value to address counter, then increment counter.
REQ-030 In FILL, wr_gnt_a and wr_gnt_b SHALL be 0 and the write pointers SHALL hold.
REQ-031 fill_done SHALL be 1 in the cycle counter equals 2**AW-1; the FSM then returns to IDLE, so FILL lasts exactly 2**AW cycles.
REQ-032 fill_start SHALL be ignored while in FILL.
REQ-033 In the cycle fill_start is sampled in IDLE, normal write arbitration SHALL still proceed.
REQ-034 Reads SHALL be arbitrated normally during FILL.
REQ-035 A read and a write to the same address in the same cycle SHALL return the pre-write data.
REQ-036 A requester SHALL not be granted on a port unless its request is high.

Reset
REQ-037 While reset=1 at an edge, the FSM SHALL go to IDLE, the counter and captured fill value SHALL clear to 0, both pointers SHALL go to A, rd_valid_a and rd_valid_b SHALL clear to 0, and fill_busy and fill_done SHALL clear to 0.
REQ-038 While reset=1, all grants and mem_write/mem_read SHALL be forced to 0.
REQ-039 A reset during FILL SHALL abort the fill immediately; locations already written keep their values.

Verification
REQ-040 After reset, wr_req_a and wr_req_b both held for 4 cycles -> grants A,B,A,B; RAM holds the corresponding data.
REQ-041 wr_req_b alone with addr 3, data 0x5A, then rd_req_a with addr 3 -> wr_gnt_b in the request cycle; rd_valid_a one cycle after rd_gnt_a with rd_data=0x5A.
REQ-042 fill_start with fill_data=0xC3 while wr_req_a is held -> fill_busy high for 16 cycles, fill_done in the 16th, wr_gnt_a=0 throughout, wr_gnt_a=1 the cycle after; all 16 addresses read 0xC3.
REQ-043 During FILL, rd_req_a and rd_req_b each read addr 0 -> alternating read grants; rd_data=0xC3 once the fill has written addr 0.
REQ-044 reset asserted at fill cycle 5 -> fill_busy=0 next cycle; addresses 0-4 hold the fill value; a new fill_start is accepted.
REQ-045 Same-address write (addr 7, 0x11 over old 0x22) and read in one cycle -> rd_data=0x22; a read one cycle later -> 0x11.
